fw_verdict_enforcer: RTL and testbench

- Sits downstream of the firewall classifier, on the sbu2cxp path, after the store-and-forward FIFO.
- Consumes the classified AXI4-Stream, where tuser[0] carries the per-packet verdict (1 = drop).
- Forwards passed packets beat-for-beat through a one-stage registered pipeline and silently discards dropped ones.
- Maintains saturating pass/drop packet counters for host telemetry.

---
 rtl/fw_verdict_enforcer.sv | 131 +++++++++++++
 tb/tb_fw_verdict_enforcer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fw_verdict_enforcer.sv
// ==========================================================================================
// fw_verdict_enforcer: forwards firewall-passed AXI4-Stream packets, discards dropped ones.
// Rev 1.0
// ==========================================================================================
`timescale 1ns/1ps
`default_nettype none

module fw_verdict_enforcer #(
  parameter int DATA_W = 256,
  parameter int USER_W = 12,
  parameter int ID_W   = 3,
  parameter int CNT_W  = 32
) (
  input  logic                mlx2sbu_clk,
  input  logic                mlx2sbu_reset,
  input  logic                in_axi4stream_vld,
  output logic                in_axi4stream_rdy,
  input  logic [DATA_W-1:0]   in_axi4stream_tdata,
  input  logic [DATA_W/8-1:0] in_axi4stream_tkeep,
  input  logic                in_axi4stream_tlast,
  input  logic [USER_W-1:0]   in_axi4stream_tuser,
  input  logic [ID_W-1:0]     in_axi4stream_tid,
  output logic                out_axi4stream_vld,
  input  logic                out_axi4stream_rdy,
  output logic [DATA_W-1:0]   out_axi4stream_tdata,
  output logic [DATA_W/8-1:0] out_axi4stream_tkeep,
  output logic                out_axi4stream_tlast,
  output logic [USER_W-1:0]   out_axi4stream_tuser,
  output logic [ID_W-1:0]     out_axi4stream_tid,
  input  logic                drop_enable,
  input  logic                cnt_clear,
  output logic [CNT_W-1:0]    pkt_pass_cnt,
  output logic [CNT_W-1:0]    pkt_drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             w_accept;
  logic             w_verdict_drop;
  logic             w_beat_drop;
  logic             w_load;
  logic             w_pass_evt;
  logic             w_drop_evt;

  // Drop packets are swallowed at line rate regardless of the output register.
  assign in_axi4stream_rdy = (r_state == S_DROP) ? 1'b1
                           : (~out_axi4stream_vld | out_axi4stream_rdy);

  assign w_accept       = in_axi4stream_vld & in_axi4stream_rdy;
  assign w_verdict_drop = drop_enable & in_axi4stream_tuser[0];
  assign w_beat_drop    = (r_state == S_DROP) | ((r_state == S_IDLE) & w_verdict_drop);
  assign w_load         = w_accept & ~w_beat_drop;
  assign w_pass_evt     = w_accept & in_axi4stream_tlast & ~w_beat_drop;
  assign w_drop_evt     = w_accept & in_axi4stream_tlast & w_beat_drop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !in_axi4stream_tlast) begin
          w_state_nxt = w_verdict_drop ? S_DROP : S_PASS;
        end
      end
      S_PASS, S_DROP: begin
        if (w_accept && in_axi4stream_tlast) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mlx2sbu_clk) begin
    if (mlx2sbu_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register: data only moves on a load, so it stays put across stalls.
  always_ff @(posedge mlx2sbu_clk) begin
    if (mlx2sbu_reset) begin
      out_axi4stream_vld   <= 1'b0;
      out_axi4stream_tdata <= '0;
      out_axi4stream_tkeep <= '0;
      out_axi4stream_tlast <= 1'b0;
      out_axi4stream_tuser <= '0;
      out_axi4stream_tid   <= '0;
    end else if (w_load) begin
      out_axi4stream_vld   <= 1'b1;
      out_axi4stream_tdata <= in_axi4stream_tdata;
      out_axi4stream_tkeep <= in_axi4stream_tkeep;
      out_axi4stream_tlast <= in_axi4stream_tlast;
      out_axi4stream_tuser <= in_axi4stream_tuser;
      out_axi4stream_tid   <= in_axi4stream_tid;
    end else if (out_axi4stream_rdy) begin
      out_axi4stream_vld   <= 1'b0;
    end
  end

  always_ff @(posedge mlx2sbu_clk) begin
    if (mlx2sbu_reset || cnt_clear) begin
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pass_evt && (r_pass_cnt != C_CNT_MAX)) begin
        r_pass_cnt <= r_pass_cnt + 1'b1;
      end
      if (w_drop_evt && (r_drop_cnt != C_CNT_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign pkt_pass_cnt = r_pass_cnt;
  assign pkt_drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fw_verdict_enforcer.sv
// ==========================================================================================
// tb_fw_verdict_enforcer: directed + random stimulus checked against a packet-level model.
// Rev 1.0
// ==========================================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fw_verdict_enforcer;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
    logic [11:0]  u;
    logic [2:0]   id;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_vld;
  logic         in_rdy;
  logic [255:0] in_tdata;
  logic [31:0]  in_tkeep;
  logic         in_tlast;
  logic [11:0]  in_tuser;
  logic [2:0]   in_tid;
  logic         out_vld;
  logic         out_rdy;
  logic [255:0] out_tdata;
  logic [31:0]  out_tkeep;
  logic         out_tlast;
  logic [11:0]  out_tuser;
  logic [2:0]   out_tid;
  logic         drop_enable;
  logic         cnt_clear;
  logic [31:0]  pass_cnt;
  logic [31:0]  drop_cnt;

  always #5 clk = ~clk;

  fw_verdict_enforcer dut (
    .mlx2sbu_clk          (clk),
    .mlx2sbu_reset        (rst),
    .in_axi4stream_vld    (in_vld),
    .in_axi4stream_rdy    (in_rdy),
    .in_axi4stream_tdata  (in_tdata),
    .in_axi4stream_tkeep  (in_tkeep),
    .in_axi4stream_tlast  (in_tlast),
    .in_axi4stream_tuser  (in_tuser),
    .in_axi4stream_tid    (in_tid),
    .out_axi4stream_vld   (out_vld),
    .out_axi4stream_rdy   (out_rdy),
    .out_axi4stream_tdata (out_tdata),
    .out_axi4stream_tkeep (out_tkeep),
    .out_axi4stream_tlast (out_tlast),
    .out_axi4stream_tuser (out_tuser),
    .out_axi4stream_tid   (out_tid),
    .drop_enable          (drop_enable),
    .cnt_clear            (cnt_clear),
    .pkt_pass_cnt         (pass_cnt),
    .pkt_drop_cnt         (drop_cnt)
  );

  // Packet-level reference: beats still owed downstream, packet position, verdict, counts.
  beat_t       q[$];
  bit          m_mid;
  bit          m_cur_drop;
  logic [31:0] m_pass;
  logic [31:0] m_drop;
  int          n_run;
  int          n_fail;
  bit          tog;

  task automatic chk(input string tag, input logic [303:0] obs, input logic [303:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t rand_beat(input bit last, input bit verdict);
    beat_t b;
    for (int i = 0; i < 8; i++) b.d[i*32 +: 32] = $urandom;
    b.k  = $urandom;
    b.l  = last;
    b.u  = 12'($urandom);
    b.u[0] = verdict;
    b.id = 3'($urandom);
    return b;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  task automatic step(input logic v, input beat_t b, input logic ordy, input logic de,
                      input logic clr, input logic r, output logic acc);
    logic  exp_rdy;
    beat_t obs;
    @(negedge clk);
    obs = '{d: out_tdata, k: out_tkeep, l: out_tlast, u: out_tuser, id: out_tid};
    chk("out_vld", 304'(out_vld), 304'(q.size() != 0));
    if (q.size() != 0) chk("out_beat", obs, q[0]);
    chk("pass_cnt", 304'(pass_cnt), 304'(m_pass));
    chk("drop_cnt", 304'(drop_cnt), 304'(m_drop));
    in_vld = v; in_tdata = b.d; in_tkeep = b.k; in_tlast = b.l; in_tuser = b.u; in_tid = b.id;
    out_rdy = ordy; drop_enable = de; cnt_clear = clr; rst = r;
    #1;
    exp_rdy = (m_mid && m_cur_drop) || (q.size() == 0) || ordy;
    if (!r) chk("in_rdy", 304'(in_rdy), 304'(exp_rdy));
    acc = v && exp_rdy && !r;
    @(posedge clk);
    if (r) begin
      q.delete(); m_mid = 0; m_cur_drop = 0; m_pass = 0; m_drop = 0;
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (acc) begin
        if (!m_mid) m_cur_drop = de && b.u[0];
        if (!m_cur_drop) q.push_back(b);
        if (b.l) begin
          if (m_cur_drop) m_drop = sat_inc(m_drop);
          else            m_pass = sat_inc(m_pass);
        end
        m_mid = !b.l;
      end
      if (clr) begin m_pass = 0; m_drop = 0; end
    end
  endtask

  // First beat carries the verdict under drop_enable=de; later beats see random tuser[0]
  // and a flipped drop_enable, neither of which may alter the packet's fate.
  task automatic send_pkt(input int n, input bit verdict, input bit de, input bit toggle_rdy,
                          input bit clr_last);
    logic  acc;
    beat_t b;
    int    tries;
    for (int i = 0; i < n; i++) begin
      b = rand_beat(i == n - 1, (i == 0) ? verdict : 1'($urandom));
      tries = 0;
      do begin
        step(1'b1, b, toggle_rdy ? tog : 1'b1, (i == 0) ? de : !de,
             clr_last && (i == n - 1), 1'b0, acc);
        tog = !tog;
        tries++;
      end while (!acc && tries < 16);
      if (!acc) chk("accept_timeout", 304'(acc), 304'(1));
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, acc);
  endtask

  task automatic check_zero_outputs();
    #2;
    chk("rst_out_vld", 304'(out_vld), 304'(0));
    chk("rst_out_data", {out_tdata, out_tkeep, out_tlast, out_tuser, out_tid}, 304'(0));
    chk("rst_pass_cnt", 304'(pass_cnt), 304'(0));
    chk("rst_drop_cnt", 304'(drop_cnt), 304'(0));
  endtask

  initial begin
    logic  acc;
    beat_t b;
    n_run = 0; n_fail = 0; tog = 1'b1;
    m_mid = 0; m_cur_drop = 0; m_pass = 0; m_drop = 0;
    in_vld = 0; in_tdata = '0; in_tkeep = '0; in_tlast = 0; in_tuser = '0; in_tid = '0;
    out_rdy = 1; drop_enable = 1; cnt_clear = 0; rst = 1;

    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    check_zero_outputs();

    // Single-beat pass, 4-beat drop, drop disabled with a drop verdict.
    send_pkt(1, 1'b0, 1'b1, 1'b0, 1'b0); idle(2);
    send_pkt(4, 1'b1, 1'b1, 1'b0, 1'b0); idle(2);
    send_pkt(3, 1'b1, 1'b0, 1'b0, 1'b0); idle(4);

    // Back-pressure: out_rdy alternates each cycle.
    send_pkt(8, 1'b0, 1'b1, 1'b1, 1'b0); idle(4);

    // Interleaved back-to-back pass / drop / pass.
    send_pkt(2, 1'b0, 1'b1, 1'b0, 1'b0);
    send_pkt(1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_pkt(1, 1'b0, 1'b1, 1'b0, 1'b0); idle(3);

    // Random traffic, including protocol-level noise on later-beat tuser and drop_enable.
    for (int i = 0; i < 400; i++) begin
      b = rand_beat(($urandom % 3) == 0, 1'($urandom));
      step(($urandom % 4) != 0, b, 1'($urandom), 1'($urandom), ($urandom % 60) == 0, 1'b0, acc);
    end
    idle(4);

    // Saturation: preload the pass counter to all-ones, then pass another packet.
    #2;
    force dut.r_pass_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_pass_cnt;
    m_pass = 32'hFFFF_FFFF;
    send_pkt(2, 1'b0, 1'b1, 1'b0, 1'b0); idle(2);

    // Clear coinciding with a tlast wins over the increment.
    send_pkt(2, 1'b0, 1'b1, 1'b0, 1'b1); idle(2);
    send_pkt(1, 1'b1, 1'b1, 1'b0, 1'b1); idle(2);

    // Reset during beat 2 of a 4-beat drop packet; beat 3 restarts as a passed packet.
    send_pkt(3, 1'b0, 1'b1, 1'b0, 1'b0); idle(1);
    step(1'b1, rand_beat(1'b0, 1'b1), 1'b1, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, rand_beat(1'b0, 1'b1), 1'b1, 1'b1, 1'b0, 1'b1, acc);
    check_zero_outputs();
    step(1'b1, rand_beat(1'b0, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, rand_beat(1'b1, 1'b1), 1'b1, 1'b1, 1'b0, 1'b0, acc);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
